// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmit path among N_REQ byte requesters.
// Optional packet locking via UART_ARB_PKT_LOCK_EN.
module uart_tx_arb #(
  parameter int N_REQ = 4,
  parameter int TMO   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_din,
  output logic               tx_en,
  input  logic               tx_rdy
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, own_q, own_d, rr_win, sel;
  logic [PW:0] sum;
  logic rr_ok, sel_ok;
  logic [7:0] cnt_q, cnt_d, din_q, din_d;
  logic [N_REQ-1:0] grant_q, grant_d, ack_q;
  logic tx_en_q;
  // Descending scan so the nearest requester after ptr is written last and wins.
  always_comb begin
    rr_ok = 1'b0;
    rr_win = '0;
    sum = '0;
    for (int j = N_REQ; j >= 1; j--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(j);
      sum = (sum >= (PW+1)'(N_REQ)) ? sum - (PW+1)'(N_REQ) : sum;
      if (req[sum[PW-1:0]]) begin
        rr_ok = 1'b1;
        rr_win = sum[PW-1:0];
      end
    end
  end
`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q, lock_d, last_q, last_d;
  assign sel_ok = lock_q ? req[own_q] : rr_ok;
  assign sel = lock_q ? own_q : rr_win;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign sel_ok = rr_ok;
  assign sel = rr_win;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    grant_d = grant_q;
    din_d = din_q;
    cnt_d = cnt_q;
`ifdef UART_ARB_PKT_LOCK_EN
    lock_d = lock_q;
    last_d = last_q;
`endif
    case (state_q)
      IDLE: if (tx_rdy && sel_ok) begin
        state_d = ISSUE;
        own_d = sel;
        grant_d = N_REQ'(1) << sel;
        din_d = req_data[{sel, 3'b000} +: 8];
`ifdef UART_ARB_PKT_LOCK_EN
        last_d = req_last[sel];
`endif
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: if (!tx_rdy || cnt_q == 8'(TMO-1)) state_d = WAIT_HI;
               else cnt_d = cnt_q + 8'd1;
      WAIT_HI: if (tx_rdy) begin
        state_d = IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
        // A packet in progress keeps its grant and leaves ptr untouched.
        lock_d = !last_q;
        grant_d = last_q ? '0 : grant_q;
        ptr_d = last_q ? own_q : ptr_q;
`else
        grant_d = '0;
        ptr_d = own_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= PW'(N_REQ-1);
      own_q <= '0;
      grant_q <= '0;
      din_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      tx_en_q <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q <= 1'b0;
      last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      grant_q <= grant_d;
      din_q <= din_d;
      cnt_q <= cnt_d;
      ack_q <= (state_q == ISSUE) ? grant_q : '0;
      tx_en_q <= (state_q == ISSUE);
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q <= lock_d;
      last_q <= last_d;
`endif
    end
  end
  assign ack = ack_q;
  assign grant = grant_q;
  assign tx_din = din_q;
  assign tx_en = tx_en_q;
endmodule
